// File: rtl/reg_timer_if.sv
// Register-side bus between the data-bus mux and a memory-mapped responder.
// The mux drives the master side; responders such as reg_timer take the slave side.
interface reg_timer_if #(
  parameter int XLEN = 32
) ();
  logic [15:0]       reg_addr;
  logic              reg_wr_en;
  logic [XLEN/8-1:0] reg_wr_be;
  logic [XLEN-1:0]   reg_wr_data;
  logic              reg_rd_en;
  logic [XLEN-1:0]   reg_rd_data;
  logic              reg_rd_ready;
  logic              reg_wr_ready;

  modport master (
    output reg_addr,
    output reg_wr_en,
    output reg_wr_be,
    output reg_wr_data,
    output reg_rd_en,
    input  reg_rd_data,
    input  reg_rd_ready,
    input  reg_wr_ready
  );

  modport slave (
    input  reg_addr,
    input  reg_wr_en,
    input  reg_wr_be,
    input  reg_wr_data,
    input  reg_rd_en,
    output reg_rd_data,
    output reg_rd_ready,
    output reg_wr_ready
  );
endinterface

// File: rtl/reg_timer.sv
// Memory-mapped 64-bit prescaled timer with a compare register, sticky match and level irq.
// All outputs are zero outside the 32-byte window so responders can be OR-combined.
module reg_timer #(
  parameter int          XLEN      = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  reg_timer_if.slave  reg_bus,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CNT_LO = 3'd2;
  localparam logic [2:0] OFF_CNT_HI = 3'd3;
  localparam logic [2:0] OFF_CMP_LO = 3'd4;
  localparam logic [2:0] OFF_CMP_HI = 3'd5;

  logic              hit;
  logic              wr_hit;
  logic              rd_hit;
  logic [2:0]        off;
  logic [XLEN-1:0]   wr_data;
  logic [XLEN/8-1:0] wr_be;
  logic              unused_addr_bits;

  logic        en;
  logic        irq_en;
  logic        auto_reload;
  logic [7:0]  prescale;
  logic        match;
  logic [7:0]  pre_cnt;
  logic [63:0] cnt;
  logic [63:0] cmp;
  logic [31:0] cnt_hi_shadow;

  logic        en_nxt;
  logic        irq_en_nxt;
  logic        auto_reload_nxt;
  logic [7:0]  prescale_nxt;
  logic        match_nxt;
  logic [7:0]  pre_cnt_nxt;
  logic [63:0] cnt_nxt;
  logic [63:0] cmp_nxt;

  logic        tick;
  logic        cnt_eq;
  logic [63:0] cnt_tick;

  logic [XLEN-1:0] rd_mux;
  logic [XLEN-1:0] rd_data_q;
  logic            rd_ready_q;
  logic            irq_q;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  assign hit              = (reg_bus.reg_addr[15:5] == BASE_ADDR[15:5]);
  assign off              = reg_bus.reg_addr[4:2];
  assign wr_hit           = reg_bus.reg_wr_en & hit;
  assign rd_hit           = reg_bus.reg_rd_en & hit;
  assign wr_data          = reg_bus.reg_wr_data;
  assign wr_be            = reg_bus.reg_wr_be;
  assign unused_addr_bits = ^reg_bus.reg_addr[1:0];

  // Prescaler only runs while enabled and restarts from zero whenever the timer is off.
  assign tick     = en && (pre_cnt == prescale);
  assign cnt_eq   = (cnt == cmp);
  assign cnt_tick = (cnt_eq && auto_reload) ? 64'd0 : cnt + 64'd1;

  always_comb begin
    if (!en)       pre_cnt_nxt = 8'd0;
    else if (tick) pre_cnt_nxt = 8'd0;
    else           pre_cnt_nxt = pre_cnt + 8'd1;
  end

  // Software writes overlay the tick result byte by byte; a match set beats a W1C clear.
  always_comb begin
    en_nxt          = en;
    irq_en_nxt      = irq_en;
    auto_reload_nxt = auto_reload;
    prescale_nxt    = prescale;
    cmp_nxt         = cmp;
    match_nxt       = match;
    cnt_nxt         = tick ? cnt_tick : cnt;

    if (wr_hit) begin
      case (off)
        OFF_CTRL: begin
          if (wr_be[0]) begin
            en_nxt          = wr_data[0];
            irq_en_nxt      = wr_data[1];
            auto_reload_nxt = wr_data[2];
          end
          if (wr_be[1]) prescale_nxt = wr_data[15:8];
        end
        OFF_STATUS: begin
          if (wr_be[0] && wr_data[0]) match_nxt = 1'b0;
        end
        OFF_CNT_LO: cnt_nxt[31:0]  = merge_bytes(cnt_nxt[31:0], wr_data, wr_be);
        OFF_CNT_HI: cnt_nxt[63:32] = merge_bytes(cnt_nxt[63:32], wr_data, wr_be);
        OFF_CMP_LO: cmp_nxt[31:0]  = merge_bytes(cmp[31:0], wr_data, wr_be);
        OFF_CMP_HI: cmp_nxt[63:32] = merge_bytes(cmp[63:32], wr_data, wr_be);
        default: ;
      endcase
    end

    if (tick && cnt_eq) match_nxt = 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:   rd_mux = {16'd0, prescale, 5'd0, auto_reload, irq_en, en};
      OFF_STATUS: rd_mux = {31'd0, match};
      OFF_CNT_LO: rd_mux = cnt[31:0];
      OFF_CNT_HI: rd_mux = cnt_hi_shadow;
      OFF_CMP_LO: rd_mux = cmp[31:0];
      OFF_CMP_HI: rd_mux = cmp[63:32];
      default:    rd_mux = '0;
    endcase
  end

  // Reading CNT_LO latches the live upper half so a following CNT_HI read is coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      en            <= 1'b0;
      irq_en        <= 1'b0;
      auto_reload   <= 1'b0;
      prescale      <= 8'd0;
      match         <= 1'b0;
      pre_cnt       <= 8'd0;
      cnt           <= 64'd0;
      cmp           <= '1;
      cnt_hi_shadow <= 32'd0;
      rd_data_q     <= '0;
      rd_ready_q    <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      en          <= en_nxt;
      irq_en      <= irq_en_nxt;
      auto_reload <= auto_reload_nxt;
      prescale    <= prescale_nxt;
      match       <= match_nxt;
      pre_cnt     <= pre_cnt_nxt;
      cnt         <= cnt_nxt;
      cmp         <= cmp_nxt;
      rd_ready_q  <= rd_hit;
      rd_data_q   <= rd_hit ? rd_mux : '0;
      irq_q       <= match & irq_en;
      if (rd_hit && (off == OFF_CNT_LO)) cnt_hi_shadow <= cnt[63:32];
    end
  end

  assign reg_bus.reg_rd_data  = rd_data_q;
  assign reg_bus.reg_rd_ready = rd_ready_q;
  assign reg_bus.reg_wr_ready = wr_hit & ~rst;
  assign irq                  = irq_q;

endmodule

// File: tb/tb_reg_timer.sv
// Self-checking bench for reg_timer: table-driven register accesses plus timed sequences,
// with read data checked through a scoreboard queue popped on every reg_rd_ready pulse.
module tb_reg_timer;

  localparam logic [15:0] BASE = 16'h0100;
  localparam logic [15:0] A_CTRL   = BASE + 16'h00;
  localparam logic [15:0] A_STATUS = BASE + 16'h04;
  localparam logic [15:0] A_CNT_LO = BASE + 16'h08;
  localparam logic [15:0] A_CNT_HI = BASE + 16'h0C;
  localparam logic [15:0] A_CMP_LO = BASE + 16'h10;
  localparam logic [15:0] A_CMP_HI = BASE + 16'h14;
  localparam logic [15:0] A_RSVD   = BASE + 16'h18;

  logic clk = 1'b0;
  logic rst;
  logic irq;

  reg_timer_if #(.XLEN(32)) bus ();

  reg_timer #(.XLEN(32), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .rst     (rst),
    .reg_bus (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic exp_ready    = 1'b0;
  bit   mon_on       = 1'b0;

  function automatic bit tb_hit(input logic [15:0] a);
    return a[15:5] == BASE[15:5];
  endfunction

  function automatic vec_t mk(input logic [15:0] a, input logic w, input logic [3:0] be,
                              input logic [31:0] d, input logic r, input logic [31:0] e,
                              input string n);
    vec_t v;
    v.addr = a; v.wr = w; v.be = be; v.wdata = d; v.rd = r; v.exp_rd = e; v.name = n;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.reg_addr    = 16'h0;
    bus.reg_wr_en   = 1'b0;
    bus.reg_wr_be   = 4'h0;
    bus.reg_wr_data = 32'h0;
    bus.reg_rd_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    drive_idle();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus cycle: push the expected read result, check the combinational write ack.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    bus.reg_addr    = v.addr;
    bus.reg_wr_en   = v.wr;
    bus.reg_wr_be   = v.be;
    bus.reg_wr_data = v.wdata;
    bus.reg_rd_en   = v.rd;
    if (v.rd && tb_hit(v.addr) && !rst) begin
      e.data = v.exp_rd;
      e.name = v.name;
      sb_q.push_back(e);
    end
    #1;
    check_output({v.name, " wr_ready"}, {31'd0, bus.reg_wr_ready},
                 {31'd0, v.wr && tb_hit(v.addr) && !rst});
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                        input string n);
    apply_stimulus(mk(a, 1'b1, be, d, 1'b0, 32'h0, n));
  endtask

  task automatic rd_reg(input logic [15:0] a, input logic [31:0] e, input string n);
    apply_stimulus(mk(a, 1'b0, 4'h0, 32'h0, 1'b1, e, n));
  endtask

  // Read responses must appear exactly one cycle after a hit read and be zero otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      check_output("rd_ready timing", {31'd0, bus.reg_rd_ready}, {31'd0, exp_ready});
      if (bus.reg_rd_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected read: got 0x%08h, expected no response", bus.reg_rd_data);
        end else begin
          e = sb_q.pop_front();
          check_output(e.name, bus.reg_rd_data, e.data);
        end
      end else begin
        check_output("rd_data idle zero", bus.reg_rd_data, 32'd0);
      end
      exp_ready = !rst && bus.reg_rd_en && tb_hit(bus.reg_addr);
    end
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    mon_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset rd_ready", {31'd0, bus.reg_rd_ready}, 32'd0);
    check_output("reset rd_data", bus.reg_rd_data, 32'd0);
    check_output("reset wr_ready", {31'd0, bus.reg_wr_ready}, 32'd0);
    check_output("reset irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    vecs.push_back(mk(A_CTRL,   0, 4'h0, 32'h0,        1, 32'h0,        "rst CTRL"));
    vecs.push_back(mk(A_STATUS, 0, 4'h0, 32'h0,        1, 32'h0,        "rst STATUS"));
    vecs.push_back(mk(A_CNT_LO, 0, 4'h0, 32'h0,        1, 32'h0,        "rst CNT_LO"));
    vecs.push_back(mk(A_CNT_HI, 0, 4'h0, 32'h0,        1, 32'h0,        "rst CNT_HI"));
    vecs.push_back(mk(A_CMP_LO, 0, 4'h0, 32'h0,        1, 32'hFFFFFFFF, "rst CMP_LO"));
    vecs.push_back(mk(A_CMP_HI, 0, 4'h0, 32'h0,        1, 32'hFFFFFFFF, "rst CMP_HI"));
    vecs.push_back(mk(A_RSVD,   0, 4'h0, 32'h0,        1, 32'h0,        "rsvd read"));
    vecs.push_back(mk(A_RSVD,   1, 4'hF, 32'hFFFFFFFF, 0, 32'h0,        "rsvd write"));
    vecs.push_back(mk(A_RSVD,   0, 4'h0, 32'h0,        1, 32'h0,        "rsvd after write"));
    vecs.push_back(mk(A_CTRL,   1, 4'hE, 32'hFFFFFFFF, 0, 32'h0,        "ctrl upper bytes"));
    vecs.push_back(mk(A_CTRL,   0, 4'h0, 32'h0,        1, 32'h0000FF00, "ctrl unused bits"));
    vecs.push_back(mk(A_CTRL,   1, 4'hF, 32'h0,        1, 32'h0000FF00, "rd+wr old data"));
    vecs.push_back(mk(A_CTRL,   0, 4'h0, 32'h0,        1, 32'h0,        "ctrl after rd+wr"));
    vecs.push_back(mk(BASE + 16'h20, 1, 4'hF, 32'h301, 0, 32'h0,        "miss wr above"));
    vecs.push_back(mk(BASE - 16'h04, 1, 4'hF, 32'h301, 0, 32'h0,        "miss wr below"));
    vecs.push_back(mk(BASE + 16'h28, 1, 4'hF, 32'h12345678, 0, 32'h0,   "miss wr cnt alias"));
    vecs.push_back(mk(BASE + 16'h20, 0, 4'h0, 32'h0,   1, 32'h0,        "miss rd above"));
    vecs.push_back(mk(BASE - 16'h04, 0, 4'h0, 32'h0,   1, 32'h0,        "miss rd below"));
    vecs.push_back(mk(A_CTRL,   0, 4'h0, 32'h0,        1, 32'h0,        "ctrl after misses"));
    vecs.push_back(mk(A_CNT_LO, 0, 4'h0, 32'h0,        1, 32'h0,        "cnt after misses"));
    vecs.push_back(mk(A_CNT_LO, 1, 4'h5, 32'hAABBCCDD, 0, 32'h0,        "cnt be 0101"));
    vecs.push_back(mk(A_CNT_LO, 0, 4'h0, 32'h0,        1, 32'h00BB00DD, "cnt be result"));
    vecs.push_back(mk(A_CNT_LO, 1, 4'h0, 32'h12345678, 0, 32'h0,        "cnt be zero"));
    vecs.push_back(mk(A_CNT_LO, 0, 4'h0, 32'h0,        1, 32'h00BB00DD, "cnt be zero no change"));
    vecs.push_back(mk(A_CNT_LO, 1, 4'hF, 32'h0,        0, 32'h0,        "cnt clear"));

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);
    idle(2);

    // PRESCALE=3: ticks land on cycles T+4, T+8, ... after the enabling write.
    wr_reg(A_CTRL, 32'h00000301, 4'hF, "prescale enable");
    idle(40);
    rd_reg(A_CNT_LO, 32'd10, "prescale count");
    wr_reg(A_CTRL, 32'h0, 4'hF, "prescale disable");
    idle(20);
    rd_reg(A_CNT_LO, 32'd10, "count frozen");

    wr_reg(A_CNT_LO, 32'h0, 4'hF, "m cnt lo");
    wr_reg(A_CNT_HI, 32'h0, 4'hF, "m cnt hi");
    wr_reg(A_CMP_LO, 32'd5, 4'hF, "m cmp lo");
    wr_reg(A_CMP_HI, 32'h0, 4'hF, "m cmp hi");
    wr_reg(A_STATUS, 32'h1, 4'hF, "m status clear");
    wr_reg(A_CTRL, 32'h00000007, 4'hF, "m enable");
    idle(6);
    check_output("irq lags match", {31'd0, irq}, 32'd0);
    rd_reg(A_STATUS, 32'h1, "match set");
    check_output("irq asserted", {31'd0, irq}, 32'd1);
    rd_reg(A_CNT_LO, 32'd1, "auto reload");
    wr_reg(A_CTRL, 32'h00000006, 4'hF, "m stop");
    wr_reg(A_STATUS, 32'h1, 4'hF, "m w1c");
    idle(1);
    check_output("irq after clear", {31'd0, irq}, 32'd0);
    rd_reg(A_CNT_LO, 32'd3, "count after stop");

    // A W1C landing in a cycle where the compare fires must leave MATCH set.
    wr_reg(A_CNT_LO, 32'd5, 4'hF, "r cnt preset");
    wr_reg(A_CTRL, 32'h00000007, 4'hF, "r enable");
    wr_reg(A_STATUS, 32'h1, 4'hF, "r clear at match");
    rd_reg(A_STATUS, 32'h1, "set wins first");
    idle(4);
    wr_reg(A_STATUS, 32'h1, 4'hF, "r clear at rematch");
    wr_reg(A_CTRL, 32'h00000006, 4'hF, "r stop");
    wr_reg(A_STATUS, 32'h0, 4'hF, "r write zero");
    wr_reg(A_STATUS, 32'h1, 4'hE, "r clear no be0");
    rd_reg(A_STATUS, 32'h1, "set wins rematch");
    wr_reg(A_STATUS, 32'h1, 4'hF, "r w1c");
    rd_reg(A_STATUS, 32'h0, "w1c clears");
    idle(1);
    check_output("irq low after w1c", {31'd0, irq}, 32'd0);

    wr_reg(A_CTRL, 32'h0, 4'hF, "c stop");
    wr_reg(A_CMP_LO, 32'hFFFFFFFF, 4'hF, "c cmp lo");
    wr_reg(A_CMP_HI, 32'hFFFFFFFF, 4'hF, "c cmp hi");
    wr_reg(A_CNT_HI, 32'h0, 4'hF, "c cnt hi");
    wr_reg(A_CNT_LO, 32'hFFFFFFFE, 4'hF, "c cnt lo");
    wr_reg(A_CTRL, 32'h00000001, 4'hF, "c enable");
    idle(1);
    rd_reg(A_CNT_LO, 32'hFFFFFFFF, "coherent lo pre carry");
    rd_reg(A_CNT_HI, 32'h0, "coherent hi pre carry");
    rd_reg(A_CNT_LO, 32'h1, "coherent lo post carry");
    rd_reg(A_CNT_HI, 32'h1, "coherent hi post carry");
    wr_reg(A_CNT_LO, 32'h0000AA00, 4'h2, "cnt write in tick");
    wr_reg(A_CTRL, 32'h0, 4'hF, "c disable");
    rd_reg(A_CNT_LO, 32'h0000AA05, "write merges tick");
    rd_reg(A_CNT_HI, 32'h1, "hi after merge");

    // An access overlapping reset is dropped and leaves reset values behind.
    rst = 1'b1;
    apply_stimulus(mk(A_CTRL, 1'b1, 4'hF, 32'h7, 1'b1, 32'h0, "access during reset"));
    rst = 1'b0;
    rd_reg(A_CTRL, 32'h0, "ctrl after reset");
    rd_reg(A_CMP_LO, 32'hFFFFFFFF, "cmp after reset");
    rd_reg(A_CNT_HI, 32'h0, "shadow after reset");
    idle(3);
    check_output("scoreboard drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
